// File: rtl/wb_xbar_pkg.sv
// rtl/wb_xbar_pkg.sv - shared constants, arbiter state encoding and clog2 helper for the WISHBONE crossbar
package wb_xbar_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Sized for the largest supported crossbar (8 masters, 16 slaves).
    localparam int MIDX_W = clog2(8);
    localparam int SIDX_W = clog2(16);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_xbar_slave_arb.sv
// rtl/wb_xbar_slave_arb.sv - per-slave arbiter: IDLE/OWNED FSM with fixed-priority or round-robin selection
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req          : per-master request for this slave (already filtered for eligibility)
//   cyc          : per-master cycle signal; the owner keeps the grant while its bit is high
//   kill         : per-master forced release (watchdog expiry)
//   owner, valid : current owner index and ownership flag (both registered)
module wb_xbar_slave_arb
    import wb_xbar_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int RR_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_M-1:0]  req,
    input  logic [NUM_M-1:0]  cyc,
    input  logic [NUM_M-1:0]  kill,
    output logic [MIDX_W-1:0] owner,
    output logic              valid
);

    arb_state_e        state, state_nxt;
    logic [MIDX_W-1:0] owner_q, owner_nxt;
    logic [MIDX_W-1:0] last_q, last_nxt;
    logic [MIDX_W-1:0] win;
    logic              win_ok;
    logic              hold;

    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        // Priority slot i maps to master (last+1+i) mod NUM_M in round-robin
        // mode, or to master i in fixed-priority mode.
        for (int i = 0; i < NUM_M; i++) begin
            for (int j = 0; j < NUM_M; j++) begin
                if (!win_ok && req[j] &&
                    j == ((RR_EN != 0) ? (int'(last_q) + 1 + i) % NUM_M : i)) begin
                    win_ok = 1'b1;
                    win    = MIDX_W'(j);
                end
            end
        end

        hold = 1'b0;
        for (int j = 0; j < NUM_M; j++) begin
            if (owner_q == MIDX_W'(j)) begin
                hold = cyc[j] && !kill[j];
            end
        end

        state_nxt = state;
        owner_nxt = owner_q;
        last_nxt  = last_q;
        case (state)
            ST_IDLE: begin
                if (win_ok) begin
                    state_nxt = ST_OWNED;
                    owner_nxt = win;
                    last_nxt  = win;
                end
            end
            ST_OWNED: begin
                // Release always passes through IDLE, so a waiting master is
                // granted one cycle after the release edge.
                if (!hold) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            owner_q <= '0;
            last_q  <= MIDX_W'(NUM_M - 1);
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            last_q  <= last_nxt;
        end
    end

    assign owner = owner_q;
    assign valid = (state == ST_OWNED);

endmodule

// File: rtl/wb_xbar_nxm.sv
// rtl/wb_xbar_nxm.sv - NUM_M x NUM_S WISHBONE crossbar with per-slave arbitration, illegal-address error and watchdog
//
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i             : per-master bus controls
//   m_adr_i, m_dat_i                   : packed master addresses / write data
//   m_dat_o, m_ack_o/m_err_o/m_rty_o   : packed read data and terminations back to masters
//   s_cyc_o/s_stb_o/s_we_o             : per-slave bus controls
//   s_adr_o, s_dat_o                   : packed low address bits / write data to slaves
//   s_dat_i, s_ack_i/s_err_i/s_rty_i   : slave read data and terminations
module wb_xbar_nxm
    import wb_xbar_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int NUM_S     = 12,
    parameter int ADR_W     = 7,
    parameter int SLV_ADR_W = 3,
    parameter int DAT_W     = 8,
    parameter int RR_EN     = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_M-1:0]           m_cyc_i,
    input  logic [NUM_M-1:0]           m_stb_i,
    input  logic [NUM_M-1:0]           m_we_i,
    input  logic [NUM_M*ADR_W-1:0]     m_adr_i,
    input  logic [NUM_M*DAT_W-1:0]     m_dat_i,
    output logic [NUM_M*DAT_W-1:0]     m_dat_o,
    output logic [NUM_M-1:0]           m_ack_o,
    output logic [NUM_M-1:0]           m_err_o,
    output logic [NUM_M-1:0]           m_rty_o,
    output logic [NUM_S-1:0]           s_cyc_o,
    output logic [NUM_S-1:0]           s_stb_o,
    output logic [NUM_S-1:0]           s_we_o,
    output logic [NUM_S*SLV_ADR_W-1:0] s_adr_o,
    output logic [NUM_S*DAT_W-1:0]     s_dat_o,
    input  logic [NUM_S*DAT_W-1:0]     s_dat_i,
    input  logic [NUM_S-1:0]           s_ack_i,
    input  logic [NUM_S-1:0]           s_err_i,
    input  logic [NUM_S-1:0]           s_rty_i
);

    localparam int IW    = ADR_W - SLV_ADR_W;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT + 1);

    function automatic logic [31:0] idx_of(input logic [ADR_W-1:0] adr);
        return 32'(adr[ADR_W-1:SLV_ADR_W]);
    endfunction

    logic [MIDX_W-1:0] arb_owner [NUM_S];
    logic [NUM_S-1:0]  arb_valid;
    logic [NUM_M-1:0]  slv_req   [NUM_S];

    logic [NUM_M-1:0]  own, r_ack, r_err, r_rty;
    logic [NUM_M-1:0]  term, stall, wd_exp, blk;
    logic [NUM_M-1:0]  ill_req, ill_fire, ill_prev, ill_err;
    logic [ADR_W-1:0]  ill_adr [NUM_M];
    logic [CNT_W-1:0]  wd_cnt  [NUM_M];

    // Master-side return path, illegal-address detection and watchdog expiry.
    always_comb begin
        m_dat_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        m_rty_o  = '0;
        own      = '0;
        r_ack    = '0;
        r_err    = '0;
        r_rty    = '0;
        term     = '0;
        stall    = '0;
        wd_exp   = '0;
        ill_req  = '0;
        ill_fire = '0;
        for (int m = 0; m < NUM_M; m++) begin
            for (int s = 0; s < NUM_S; s++) begin
                if (arb_valid[s] && arb_owner[s] == MIDX_W'(m)) begin
                    own[m]   = 1'b1;
                    r_ack[m] = s_ack_i[s];
                    r_err[m] = s_err_i[s];
                    r_rty[m] = s_rty_i[s];
                    m_dat_o[m*DAT_W +: DAT_W] = s_dat_i[s*DAT_W +: DAT_W];
                end
            end
            m_ack_o[m] = r_ack[m] && m_stb_i[m];
            m_rty_o[m] = r_rty[m] && m_stb_i[m];

            ill_req[m]  = m_cyc_i[m] && m_stb_i[m] &&
                          (idx_of(m_adr_i[m*ADR_W +: ADR_W]) >= 32'(NUM_S));
            // Fire once per strobe/address; a held strobe on the same bad
            // address does not re-trigger.
            ill_fire[m] = ill_req[m] &&
                          !(ill_prev[m] && m_adr_i[m*ADR_W +: ADR_W] == ill_adr[m]);

            // Watchdog expiry is excluded from term so that a slave
            // termination in the expiry cycle takes precedence.
            term[m]   = m_ack_o[m] || m_rty_o[m] || (r_err[m] && m_stb_i[m]) || ill_err[m];
            stall[m]  = m_stb_i[m] && !term[m];
            // Counter holds the stalls before this cycle; expiry is on the
            // TIMEOUT-th stalled cycle.
            wd_exp[m] = (TIMEOUT != 0) && stall[m] && (wd_cnt[m] == CNT_W'(TIMEOUT - 1));

            m_err_o[m] = (r_err[m] && m_stb_i[m]) || ill_err[m] || wd_exp[m];
        end
    end

    // A master may request only while it owns nothing and is not locked out
    // by a watchdog expiry.
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            slv_req[s] = '0;
            for (int m = 0; m < NUM_M; m++) begin
                slv_req[s][m] = m_cyc_i[m] && m_stb_i[m] && !own[m] && !blk[m] &&
                                (idx_of(m_adr_i[m*ADR_W +: ADR_W]) == 32'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_arb
        wb_xbar_slave_arb #(
            .NUM_M (NUM_M),
            .RR_EN (RR_EN)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req   (slv_req[s]),
            .cyc   (m_cyc_i),
            .kill  (wd_exp),
            .owner (arb_owner[s]),
            .valid (arb_valid[s])
        );
    end

    // Slave-side forwarding from the current owner.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int s = 0; s < NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (arb_valid[s] && arb_owner[s] == MIDX_W'(m)) begin
                    s_cyc_o[s] = m_cyc_i[m];
                    s_stb_o[s] = m_stb_i[m];
                    s_we_o[s]  = m_we_i[m];
                    s_adr_o[s*SLV_ADR_W +: SLV_ADR_W] = m_adr_i[m*ADR_W +: SLV_ADR_W];
                    s_dat_o[s*DAT_W +: DAT_W]         = m_dat_i[m*DAT_W +: DAT_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk      <= '0;
            ill_prev <= '0;
            ill_err  <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                wd_cnt[m]  <= '0;
                ill_adr[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (!stall[m] || wd_exp[m]) begin
                    wd_cnt[m] <= '0;
                end else begin
                    wd_cnt[m] <= wd_cnt[m] + CNT_W'(1);
                end
                // Lockout after expiry lasts until cyc has been seen low.
                if (wd_exp[m]) begin
                    blk[m] <= 1'b1;
                end else if (!m_cyc_i[m]) begin
                    blk[m] <= 1'b0;
                end
                ill_prev[m] <= ill_req[m];
                ill_adr[m]  <= m_adr_i[m*ADR_W +: ADR_W];
                ill_err[m]  <= ill_fire[m];
            end
        end
    end

endmodule

// File: tb/tb_wb_xbar_nxm.sv
// tb/tb_wb_xbar_nxm.sv - self-checking bench for wb_xbar_nxm (round-robin and fixed-priority instances)
module tb_wb_xbar_nxm;

    localparam int NM = 2;
    localparam int NS = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     m_cyc, m_stb, m_we;
    logic [13:0]    m_adr;
    logic [15:0]    m_dat_w;
    logic [11:0]    s_ack, s_err, s_rty;
    logic [95:0]    s_dat_i;

    logic [15:0]    m_dat_r, f_m_dat_r;
    logic [1:0]     m_ack, m_err, m_rty, f_m_ack, f_m_err, f_m_rty;
    logic [11:0]    s_cyc, s_stb, s_we, f_s_cyc, f_s_stb, f_s_we;
    logic [35:0]    s_adr, f_s_adr;
    logic [95:0]    s_dat_o, f_s_dat_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_xbar_nxm #(.NUM_M(NM), .NUM_S(NS), .ADR_W(7), .SLV_ADR_W(3), .DAT_W(8),
                  .RR_EN(1), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat_w),
        .m_dat_o(m_dat_r), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
    );

    wb_xbar_nxm #(.NUM_M(NM), .NUM_S(NS), .ADR_W(7), .SLV_ADR_W(3), .DAT_W(8),
                  .RR_EN(0), .TIMEOUT(8)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat_w),
        .m_dat_o(f_m_dat_r), .m_ack_o(f_m_ack), .m_err_o(f_m_err), .m_rty_o(f_m_rty),
        .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_adr_o(f_s_adr), .s_dat_o(f_s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv(input int m, input bit c, input bit s, input bit w,
                       input logic [6:0] a, input logic [7:0] d);
        m_cyc[m] = c;
        m_stb[m] = s;
        m_we[m]  = w;
        m_adr[m*7 +: 7]   = a;
        m_dat_w[m*8 +: 8] = d;
    endtask

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
        s_ack = '0; s_err = '0; s_rty = '0; s_dat_i = '0;

        // Reset state
        nxt(); nxt(); mid();
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_mterm", 32'({m_ack, m_err, m_rty}), 32'h0);
        chk("rst_mdat", 32'(m_dat_r), 32'h0);
        nxt(); rst = 1'b0;

        // Single write m0 -> slave 3, adr 0x1D
        nxt(); drv(0, 1, 1, 1, 7'h1D, 8'h5A); mid();
        chk("t1_latency", 32'(s_cyc), 32'h0);
        nxt(); s_ack[3] = 1'b1; mid();
        chk("t1_fwd", 32'({s_cyc[3], s_stb[3], s_we[3], s_adr[9 +: 3], s_dat_o[24 +: 8]}),
            32'({3'b111, 3'd5, 8'h5A}));
        chk("t1_ack", 32'(m_ack), 32'h1);
        nxt(); s_ack[3] = 1'b0; drv(0, 0, 0, 0, 7'h0, 8'h0);
        nxt();

        // Both masters on slave 5 (m0 low bits 1, m1 low bits 6)
        nxt(); drv(0, 1, 1, 0, 7'h29, 8'h0); drv(1, 1, 1, 0, 7'h2E, 8'h0); s_dat_i[40 +: 8] = 8'hC3;
        nxt(); s_ack[5] = 1'b1; mid();
        chk("rr_first", 32'({s_cyc[5], s_adr[15 +: 3]}), 32'({1'b1, 3'd1}));
        chk("fp_first", 32'({f_s_cyc[5], f_s_adr[15 +: 3]}), 32'({1'b1, 3'd1}));
        chk("rr_rdata", 32'(m_dat_r), 32'h00C3);
        chk("rr_ack0", 32'(m_ack), 32'h1);
        nxt(); s_ack[5] = 1'b0; drv(0, 0, 0, 0, 7'h0, 8'h0);
        nxt(); mid();
        chk("rr_gap", 32'(s_cyc[5]), 32'h0);
        nxt(); s_ack[5] = 1'b1; mid();
        chk("rr_second", 32'({s_cyc[5], s_adr[15 +: 3]}), 32'({1'b1, 3'd6}));
        chk("rr_ack1", 32'(m_ack), 32'h2);
        nxt(); s_ack[5] = 1'b0; drv(1, 0, 0, 0, 7'h0, 8'h0);
        nxt();
        nxt(); drv(0, 1, 1, 0, 7'h29, 8'h0); drv(1, 1, 1, 0, 7'h2E, 8'h0);
        nxt(); s_ack[5] = 1'b1; mid();
        chk("rr_rotate", 32'(s_adr[15 +: 3]), 32'd1);
        nxt(); s_ack[5] = 1'b0; drv(0, 0, 0, 0, 7'h0, 8'h0);
        nxt(); drv(0, 1, 1, 0, 7'h29, 8'h0); mid();
        chk("rr_no_handover", 32'({s_cyc[5], f_s_cyc[5]}), 32'h0);
        nxt(); s_ack[5] = 1'b1; mid();
        chk("rr_alt", 32'(s_adr[15 +: 3]), 32'd6);
        chk("fp_fixed", 32'(f_s_adr[15 +: 3]), 32'd1);
        chk("rr_alt_ack", 32'({m_ack, f_m_ack}), 32'({2'b10, 2'b01}));
        nxt(); s_ack[5] = 1'b0; drv(0, 0, 0, 0, 7'h0, 8'h0); drv(1, 0, 0, 0, 7'h0, 8'h0);
        nxt();

        // Illegal address 0x70 (index 14) from m1, then an address change while held
        nxt(); drv(1, 1, 1, 0, 7'h70, 8'h0); mid();
        chk("ill_pre", 32'(m_err[1]), 32'h0);
        nxt(); mid();
        chk("ill_pulse", 32'({m_err[1], s_cyc}), 32'({1'b1, 12'h0}));
        nxt(); mid();
        chk("ill_once", 32'(m_err[1]), 32'h0);
        nxt(); drv(1, 1, 1, 0, 7'h68, 8'h0); mid();
        chk("ill_nochg", 32'(m_err[1]), 32'h0);
        nxt(); mid();
        chk("ill_newadr", 32'(m_err[1]), 32'h1);
        nxt(); drv(1, 0, 0, 0, 7'h0, 8'h0);
        nxt();

        // Watchdog: slave 2 never acks m0; m1 queues from the 4th stalled cycle
        for (int k = 1; k <= 8; k++) begin
            nxt();
            if (k == 1) drv(0, 1, 1, 0, 7'h10, 8'h0);
            if (k == 4) drv(1, 1, 1, 0, 7'h13, 8'h0);
            mid();
            chk($sformatf("wd_err_%0d", k), 32'(m_err[0]), 32'(k == 8));
            if (k >= 2) chk($sformatf("wd_hold_%0d", k), 32'(s_cyc[2]), 32'h1);
        end
        nxt(); mid();
        chk("wd_release", 32'({s_cyc[2], m_err[0]}), 32'h0);
        nxt(); s_ack[2] = 1'b1; mid();
        chk("wd_regrant", 32'({s_cyc[2], s_adr[6 +: 3], m_ack}), 32'({1'b1, 3'd3, 2'b10}));
        nxt(); s_ack[2] = 1'b0; drv(1, 0, 0, 0, 7'h0, 8'h0);
        nxt();
        nxt(); mid();
        chk("wd_block", 32'(s_cyc[2]), 32'h0);
        nxt(); drv(0, 0, 0, 0, 7'h0, 8'h0);
        nxt();

        // Reset during a read on slave 0
        nxt(); drv(0, 1, 1, 0, 7'h02, 8'h0);
        nxt(); s_dat_i[0 +: 8] = 8'h77; mid();
        chk("rstm_own", 32'(s_cyc[0]), 32'h1);
        rst = 1'b1;
        nxt(); rst = 1'b0; drv(0, 0, 0, 0, 7'h0, 8'h0); drv(1, 1, 1, 0, 7'h04, 8'h0); s_ack[0] = 1'b1; mid();
        chk("rstm_scyc", 32'({s_cyc, s_stb}), 32'h0);
        chk("rstm_mout", 32'({m_ack, m_err, m_rty, m_dat_r}), 32'h0);
        nxt(); mid();
        chk("rstm_regrant", 32'({s_cyc[0], s_adr[0 +: 3], m_ack}), 32'({1'b1, 3'd4, 2'b10}));
        nxt(); s_ack[0] = 1'b0; drv(1, 0, 0, 0, 7'h0, 8'h0);
        nxt();

        // Randomized single-master transactions against the address-map model
        for (int t = 0; t < 40; t++) begin
            int m, a, idx, dly, resp;
            bit we;
            logic [7:0] wd, rd;
            m    = $urandom_range(0, 1);
            a    = $urandom_range(0, 127);
            we   = 1'($urandom_range(0, 1));
            wd   = 8'($urandom_range(0, 255));
            rd   = 8'($urandom_range(0, 255));
            dly  = $urandom_range(0, 3);
            resp = $urandom_range(0, 2);
            idx  = a / 8;
            nxt(); drv(m, 1, 1, we, 7'(a), wd); mid();
            chk("rnd_gap", 32'(s_cyc), 32'h0);
            nxt(); mid();
            if (idx < NS) begin
                chk("rnd_fwd",
                    32'({s_cyc[idx], s_stb[idx], s_we[idx], s_adr[idx*3 +: 3], s_dat_o[idx*8 +: 8]}),
                    32'({1'b1, 1'b1, we, 3'(a % 8), wd}));
                for (int d = 0; d < dly; d++) begin
                    nxt(); mid();
                    chk("rnd_wait", 32'({m_ack[m], m_err[m], m_rty[m], s_cyc[idx]}), 32'h1);
                end
                nxt();
                s_ack[idx] = (resp == 0);
                s_err[idx] = (resp == 1);
                s_rty[idx] = (resp == 2);
                s_dat_i[idx*8 +: 8] = rd;
                mid();
                chk("rnd_term", 32'({m_ack[m], m_err[m], m_rty[m], m_dat_r[m*8 +: 8]}),
                    32'({resp == 0, resp == 1, resp == 2, rd}));
            end else begin
                chk("rnd_ill", 32'({m_err[m], s_cyc}), 32'({1'b1, 12'h0}));
            end
            nxt(); drv(m, 0, 0, 0, 7'h0, 8'h0); s_ack = '0; s_err = '0; s_rty = '0;
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
